rotate_fifo_sched: RTL and testbench

- Front-end scheduler for the rotating FIFO datapath. That datapath executes one command per cycle with priority rotate > read > write, and finishes its rotation data move one cycle after the command.
- This block shares the FIFO between NUM_WR write requesters, one read consumer and one rotation command source. It issues at most one FIFO command per cycle, legal for the current FIFO status.
- It enforces the post-rotation settle cycle and bounds write starvation under sustained reads.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rotate_fifo_sched.sv | 119 +++++++++++
 tb/tb_rotate_fifo_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the rotating FIFO front end: scheduler states and
// rotation direction encoding.
package fifo_pkg;

    typedef enum logic {
        StIdle      = 1'b0,
        StRotSettle = 1'b1
    } sched_state_e;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the
// pointer, wrapping modulo NUM_WR.
module rr_arbiter #(
    parameter int unsigned NUM_WR = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_WR)
) (
    input  logic [NUM_WR-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_WR-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    logic [IDX_W-1:0] w_cand;

    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off);
        return (base + off) % NUM_WR;
    endfunction

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            w_cand = IDX_W'(wrap_add(32'(i_ptr), k));
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotate_fifo_sched.sv
// Single-command-per-cycle scheduler for the rotating FIFO: rotate > read > write,
// one settle cycle after each legal rotation, bounded write starvation.
module rotate_fifo_sched #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
    parameter int unsigned NUM_WR       = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            i_wr_valid,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_WR-1:0]            o_wr_ready,
    input  logic                         i_rd_valid,
    output logic                         o_rd_ready,
    input  logic                         i_rot_valid,
    input  logic [ADDR_WIDTH-1:0]        i_rot_amount,
    input  logic                         i_rot_dir,
    output logic                         o_rot_ready,
    output logic                         o_rot_nop,
    output logic                         o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]        o_fifo_wr_data,
    output logic                         o_fifo_rd_en,
    output logic                         o_fifo_rotate_en,
    output logic [ADDR_WIDTH-1:0]        o_fifo_rotate_amount,
    output logic                         o_fifo_rotate_dir,
    input  logic                         i_fifo_full,
    input  logic                         i_fifo_empty,
    input  logic [ADDR_WIDTH:0]          i_fifo_count,
    output logic                         o_busy
);

    import fifo_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_WR);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    sched_state_e     r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_rot_nop;

    logic              w_idle;
    logic              w_rot_legal;
    logic              w_wr_elig;
    logic              w_starved;
    logic              w_rot_gnt;
    logic              w_rd_gnt;
    logic              w_wr_gnt;
    logic              w_rot_en;
    logic              w_arb_valid;
    logic [NUM_WR-1:0] w_arb_gnt;
    logic [IDX_W-1:0]  w_arb_idx;

    rr_arbiter #(
        .NUM_WR(NUM_WR),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req  (i_wr_valid),
        .i_ptr  (r_rr_ptr),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_valid(w_arb_valid)
    );

    // Every grant is qualified by rst_n so all strobes drop the moment reset asserts.
    assign w_idle      = rst_n && (r_state == StIdle);
    assign w_rot_legal = (i_fifo_count != '0) && (i_rot_amount != '0) &&
                         ({1'b0, i_rot_amount} < i_fifo_count);
    assign w_wr_elig   = (|i_wr_valid) && !i_fifo_full;
    assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) && w_wr_elig;

    assign w_rot_gnt = w_idle && i_rot_valid;
    assign w_rot_en  = w_rot_gnt && w_rot_legal;
    assign w_rd_gnt  = w_idle && !i_rot_valid && i_rd_valid && !i_fifo_empty && !w_starved;
    assign w_wr_gnt  = w_idle && !i_rot_valid && !w_rd_gnt && w_wr_elig && w_arb_valid;

    assign o_rot_ready          = w_rot_gnt;
    assign o_fifo_rotate_en     = w_rot_en;
    assign o_fifo_rotate_amount = w_rot_en ? i_rot_amount : '0;
    assign o_fifo_rotate_dir    = (w_rot_en && (i_rot_dir == ROT_RIGHT)) ? ROT_RIGHT : ROT_LEFT;
    assign o_rd_ready           = w_rd_gnt;
    assign o_fifo_rd_en         = w_rd_gnt;
    assign o_wr_ready           = w_wr_gnt ? w_arb_gnt : '0;
    assign o_fifo_wr_en         = w_wr_gnt;
    assign o_fifo_wr_data       = w_wr_gnt ?
                                  i_wr_data[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_busy               = rst_n && (r_state == StRotSettle);
    assign o_rot_nop            = r_rot_nop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_rr_ptr     <= '0;
            r_starve_cnt <= '0;
            r_rot_nop    <= 1'b0;
        end else begin
            r_rot_nop <= w_rot_gnt && !w_rot_legal;

            case (r_state)
                StIdle:      if (w_rot_en) r_state <= StRotSettle;
                StRotSettle: r_state <= StIdle;
                default:     r_state <= StIdle;
            endcase

            if (!w_wr_elig || w_wr_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_rd_gnt && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (w_wr_gnt) begin
                r_rr_ptr <= (w_arb_idx == IDX_W'(NUM_WR - 1)) ? '0 : w_arb_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rotate_fifo_sched.sv
// Directed bench for rotate_fifo_sched: a per-cycle reference model plus
// hand-computed expectations for round robin, gating, rotation, starvation and reset.
module tb_rotate_fifo_sched;

    import fifo_pkg::*;

    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int NWR    = 4;
    localparam int SLIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NWR-1:0]  wr_valid;
    logic [NWR*DW-1:0] wr_data;
    logic            rd_valid;
    logic            rot_valid;
    logic [AW-1:0]   rot_amount;
    logic            rot_dir;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;

    logic [NWR-1:0]  dut_wr_ready;
    logic            dut_rd_ready;
    logic            dut_rot_ready;
    logic            dut_rot_nop;
    logic            dut_wr_en;
    logic [DW-1:0]   dut_wr_data;
    logic            dut_rd_en;
    logic            dut_rot_en;
    logic [AW-1:0]   dut_rot_amount;
    logic            dut_rot_dir;
    logic            dut_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rotate_fifo_sched #(
        .DATA_WIDTH  (DW),
        .DEPTH       (8),
        .ADDR_WIDTH  (AW),
        .NUM_WR      (NWR),
        .STARVE_LIMIT(SLIMIT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_wr_valid          (wr_valid),
        .i_wr_data           (wr_data),
        .o_wr_ready          (dut_wr_ready),
        .i_rd_valid          (rd_valid),
        .o_rd_ready          (dut_rd_ready),
        .i_rot_valid         (rot_valid),
        .i_rot_amount        (rot_amount),
        .i_rot_dir           (rot_dir),
        .o_rot_ready         (dut_rot_ready),
        .o_rot_nop           (dut_rot_nop),
        .o_fifo_wr_en        (dut_wr_en),
        .o_fifo_wr_data      (dut_wr_data),
        .o_fifo_rd_en        (dut_rd_en),
        .o_fifo_rotate_en    (dut_rot_en),
        .o_fifo_rotate_amount(dut_rot_amount),
        .o_fifo_rotate_dir   (dut_rot_dir),
        .i_fifo_full         (fifo_full),
        .i_fifo_empty        (fifo_empty),
        .i_fifo_count        (fifo_count),
        .o_busy              (dut_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: settle flag, pending nop pulse, write pointer, read streak.
    bit       m_settle;
    bit       m_nop;
    int       m_ptr;
    int       m_starve;

    logic [NWR-1:0] e_wr_ready;
    logic [DW-1:0]  e_wr_data;
    logic           e_rd;
    logic           e_rot_ready;
    logic           e_rot_en;
    logic [AW-1:0]  e_rot_amount;
    logic           e_rot_dir;
    logic           e_elig;
    logic [1:0]     e_g;
    logic [1:0]     m_cand;
    bit             m_found;

    always_comb begin
        e_wr_ready   = '0;
        e_wr_data    = '0;
        e_rd         = 1'b0;
        e_rot_ready  = 1'b0;
        e_rot_en     = 1'b0;
        e_rot_amount = '0;
        e_rot_dir    = 1'b0;
        e_g          = '0;
        m_cand       = '0;
        m_found      = 1'b0;
        e_elig       = (wr_valid != '0) && !fifo_full;
        if (rst_n && !m_settle) begin
            if (rot_valid) begin
                e_rot_ready = 1'b1;
                if (fifo_count > 0 && rot_amount != 0 && int'(rot_amount) < int'(fifo_count)) begin
                    e_rot_en     = 1'b1;
                    e_rot_amount = rot_amount;
                    e_rot_dir    = rot_dir;
                end
            end else if (rd_valid && !fifo_empty && !(m_starve == SLIMIT && e_elig)) begin
                e_rd = 1'b1;
            end else if (e_elig) begin
                for (int k = 0; k < NWR; k++) begin
                    m_cand = 2'((m_ptr + k) % NWR);
                    if (!m_found && wr_valid[m_cand]) begin
                        m_found = 1'b1;
                        e_g     = m_cand;
                    end
                end
                e_wr_ready[e_g] = 1'b1;
                e_wr_data       = wr_data[int'(e_g)*DW +: DW];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_settle <= 1'b0;
            m_nop    <= 1'b0;
            m_ptr    <= 0;
            m_starve <= 0;
        end else begin
            m_nop    <= e_rot_ready && !e_rot_en;
            m_settle <= e_rot_en;
            if (!e_elig || e_wr_ready != '0) m_starve <= 0;
            else if (e_rd && m_starve < SLIMIT) m_starve <= m_starve + 1;
            if (e_wr_ready != '0) m_ptr <= (int'(e_g) + 1) % NWR;
        end
    end

    always @(negedge clk) begin
        chk("m_wr_ready", 32'(dut_wr_ready), 32'(e_wr_ready));
        chk("m_wr_en", 32'(dut_wr_en), 32'(e_wr_ready != '0));
        chk("m_wr_data", 32'(dut_wr_data), 32'(e_wr_data));
        chk("m_rd_ready", 32'(dut_rd_ready), 32'(e_rd));
        chk("m_rd_en", 32'(dut_rd_en), 32'(e_rd));
        chk("m_rot_ready", 32'(dut_rot_ready), 32'(e_rot_ready));
        chk("m_rot_en", 32'(dut_rot_en), 32'(e_rot_en));
        chk("m_rot_amount", 32'(dut_rot_amount), 32'(e_rot_amount));
        chk("m_rot_dir", 32'(dut_rot_dir), 32'(e_rot_dir));
        chk("m_rot_nop", 32'(dut_rot_nop), 32'(m_nop));
        chk("m_busy", 32'(dut_busy), 32'(rst_n && m_settle));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_valid   = 4'hF;
        wr_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        rd_valid   = 1'b0;
        rot_valid  = 1'b0;
        rot_amount = '0;
        rot_dir    = ROT_LEFT;
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        fifo_count = 4'd4;

        @(negedge clk);
        chk("rst_wr_ready", 32'(dut_wr_ready), 32'h0);
        chk("rst_busy", 32'(dut_busy), 32'h0);
        chk("rst_rot_nop", 32'(dut_rot_nop), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Round robin over all four requesters from pointer 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_grant", 32'(dut_wr_ready), 32'(1) << (i % 4));
            chk("rr_data", 32'(dut_wr_data), 32'((i % 4 + 1) * 8'h11));
            cyc();
        end

        fifo_full  = 1'b1;
        fifo_count = 4'd8;
        @(negedge clk);
        chk("full_wr_ready", 32'(dut_wr_ready), 32'h0);
        chk("full_wr_en", 32'(dut_wr_en), 32'h0);
        cyc();
        rd_valid = 1'b1;
        @(negedge clk);
        chk("full_rd_ready", 32'(dut_rd_ready), 32'h1);
        chk("full_wr_en_rd", 32'(dut_wr_en), 32'h0);
        cyc();

        // Legal rotation with a read waiting behind it.
        fifo_full  = 1'b0;
        fifo_count = 4'd5;
        wr_valid   = 4'h0;
        rot_valid  = 1'b1;
        rot_amount = 3'd2;
        rot_dir    = ROT_RIGHT;
        @(negedge clk);
        chk("rot_en", 32'(dut_rot_en), 32'h1);
        chk("rot_amount", 32'(dut_rot_amount), 32'h2);
        chk("rot_dir", 32'(dut_rot_dir), 32'h1);
        chk("rot_rd_blocked", 32'(dut_rd_ready), 32'h0);
        cyc();
        rot_valid = 1'b0;
        @(negedge clk);
        chk("settle_busy", 32'(dut_busy), 32'h1);
        chk("settle_rd", 32'(dut_rd_ready), 32'h0);
        chk("settle_rot_en", 32'(dut_rot_en), 32'h0);
        cyc();
        @(negedge clk);
        chk("post_settle_rd", 32'(dut_rd_ready), 32'h1);
        chk("post_settle_busy", 32'(dut_busy), 32'h0);
        cyc();

        // Illegal rotations: amount == count, then empty FIFO with amount 0.
        rd_valid   = 1'b0;
        fifo_count = 4'd3;
        rot_amount = 3'd3;
        rot_valid  = 1'b1;
        @(negedge clk);
        chk("ill_rot_ready", 32'(dut_rot_ready), 32'h1);
        chk("ill_rot_en", 32'(dut_rot_en), 32'h0);
        cyc();
        rot_valid = 1'b0;
        rd_valid  = 1'b1;
        @(negedge clk);
        chk("ill_nop", 32'(dut_rot_nop), 32'h1);
        chk("ill_busy", 32'(dut_busy), 32'h0);
        chk("ill_rd_next", 32'(dut_rd_ready), 32'h1);
        cyc();
        rd_valid   = 1'b0;
        fifo_count = 4'd0;
        fifo_empty = 1'b1;
        rot_amount = 3'd0;
        rot_valid  = 1'b1;
        @(negedge clk);
        chk("ill0_rot_ready", 32'(dut_rot_ready), 32'h1);
        chk("ill0_rot_en", 32'(dut_rot_en), 32'h0);
        cyc();
        rot_valid = 1'b0;
        @(negedge clk);
        chk("ill0_nop", 32'(dut_rot_nop), 32'h1);
        chk("ill0_busy", 32'(dut_busy), 32'h0);
        cyc();
        @(negedge clk);
        chk("nop_pulse_end", 32'(dut_rot_nop), 32'h0);
        cyc();

        // Starvation bound: four reads, one write to requester 1, then reads again.
        fifo_empty = 1'b0;
        fifo_count = 4'd4;
        rd_valid   = 1'b1;
        wr_valid   = 4'b0010;
        for (int k = 0; k < SLIMIT; k++) begin
            @(negedge clk);
            chk("starve_rd", 32'(dut_rd_ready), 32'h1);
            chk("starve_no_wr", 32'(dut_wr_ready), 32'h0);
            cyc();
        end
        @(negedge clk);
        chk("starve_wr", 32'(dut_wr_ready), 32'h2);
        chk("starve_wr_data", 32'(dut_wr_data), 32'h22);
        chk("starve_rd_off", 32'(dut_rd_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("starve_rd_resume", 32'(dut_rd_ready), 32'h1);
        cyc();

        // Reset asserted during the settle cycle.
        rd_valid   = 1'b0;
        wr_valid   = 4'hF;
        fifo_count = 4'd5;
        rot_amount = 3'd1;
        rot_dir    = ROT_LEFT;
        rot_valid  = 1'b1;
        @(negedge clk);
        chk("rst_rot_en", 32'(dut_rot_en), 32'h1);
        cyc();
        rot_valid = 1'b0;
        @(negedge clk);
        chk("rst_settle_busy", 32'(dut_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(dut_busy), 32'h0);
        chk("mid_rst_wr", 32'(dut_wr_ready), 32'h0);
        chk("mid_rst_wr_en", 32'(dut_wr_en), 32'h0);
        chk("mid_rst_rot_en", 32'(dut_rot_en), 32'h0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_wr", 32'(dut_wr_ready), 32'h1);
        chk("after_rst_busy", 32'(dut_busy), 32'h0);
        cyc();
        @(negedge clk);
        chk("after_rst_wr2", 32'(dut_wr_ready), 32'h2);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
